// File: rtl/player_controller.sv
// Player sprite sequencer: position from debounced keys with playfield clamping,
// per-character animation frames on frame ticks, respawn on game-state change.
module player_controller #(
  parameter int unsigned FRAMES   = 4,
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned MOVE_DIV = 2,
  parameter int unsigned STEP     = 1,
  parameter int unsigned SPAWN_X  = 20,
  parameter int unsigned SPAWN_Y  = 110,
  parameter int unsigned X_MAX    = 310,
  parameter int unsigned Y_MAX    = 230
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic        frame_tick,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  output logic [8:0]  player_x,
  output logic [8:0]  player_y,
  output logic [11:0] player_state,
  output logic        moving
);

  localparam int unsigned AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int unsigned MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef enum logic [1:0] {SPAWN, IDLE, MOVE} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [3:0]    state_q;
  logic [AW-1:0] anim_q, anim_d;
  logic [MW-1:0] move_q, move_d;
  logic [8:0]    x_d, y_d;
  logic [11:0]   ps_d;
  logic          moving_d;

  logic       state_chg, any_key, in_stage, spawn, anim_wrap, step_now;
  logic [9:0] x_dec, x_inc, y_dec, y_inc;
  logic [8:0] x_lo, x_hi, y_lo, y_hi;

  assign state_chg = (state != state_q);
  assign any_key   = key_up | key_down | key_left | key_right;
  assign in_stage  = (state_q == 4'd2) || (state_q == 4'd4) || (state_q == 4'd6);
  assign spawn     = state_chg || (fsm_q == SPAWN);
  assign anim_wrap = frame_tick && (anim_q == AW'(ANIM_DIV - 1));
  assign step_now  = frame_tick && (fsm_q == MOVE) && (move_q == MW'(MOVE_DIV - 1));

  // One bit of headroom so a decrement below zero shows up in bit 9
  assign x_dec = {1'b0, player_x} - 10'(STEP);
  assign x_inc = {1'b0, player_x} + 10'(STEP);
  assign y_dec = {1'b0, player_y} - 10'(STEP);
  assign y_inc = {1'b0, player_y} + 10'(STEP);
  assign x_lo  = x_dec[9] ? 9'd0 : x_dec[8:0];
  assign y_lo  = y_dec[9] ? 9'd0 : y_dec[8:0];
  assign x_hi  = (x_inc > 10'(X_MAX)) ? 9'(X_MAX) : x_inc[8:0];
  assign y_hi  = (y_inc > 10'(Y_MAX)) ? 9'(Y_MAX) : y_inc[8:0];

  function automatic logic [3:0] adv(input logic [3:0] nib);
    return (nib >= 4'(FRAMES - 1)) ? 4'd0 : nib + 4'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= IDLE;
      state_q      <= 4'd0;
      anim_q       <= '0;
      move_q       <= '0;
      player_x     <= 9'(SPAWN_X);
      player_y     <= 9'(SPAWN_Y);
      player_state <= 12'd0;
      moving       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state;
      anim_q       <= anim_d;
      move_q       <= move_d;
      player_x     <= x_d;
      player_y     <= y_d;
      player_state <= ps_d;
      moving       <= moving_d;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    anim_d = anim_q;
    move_d = move_q;
    x_d    = player_x;
    y_d    = player_y;
    ps_d   = player_state;

    if (state_chg) begin
      fsm_d = SPAWN;
    end else begin
      case (fsm_q)
        SPAWN:   fsm_d = IDLE;
        IDLE:    if (any_key) fsm_d = MOVE;
        MOVE:    if (!any_key) fsm_d = IDLE;
        default: fsm_d = SPAWN;
      endcase
    end

    if (spawn) begin
      // Respawn drops any coincident tick and restarts both dividers
      x_d    = 9'(SPAWN_X);
      y_d    = 9'(SPAWN_Y);
      anim_d = '0;
      move_d = '0;
    end else begin
      if (frame_tick) begin
        anim_d = anim_wrap ? '0 : anim_q + AW'(1);
      end
      if (frame_tick && (fsm_q == MOVE)) begin
        move_d = step_now ? '0 : move_q + MW'(1);
      end
      if (fsm_d == IDLE) begin
        move_d = '0;
      end

      if (step_now && in_stage) begin
        if (key_up)         y_d = y_lo;
        else if (key_down)  y_d = y_hi;
        else if (key_left)  x_d = x_lo;
        else if (key_right) x_d = x_hi;
      end

      if (anim_wrap) begin
        if (state_q == 4'd0) begin
          for (int n = 0; n < 3; n++) ps_d[4*n +: 4] = adv(player_state[4*n +: 4]);
        end else begin
          for (int n = 0; n < 3; n++) begin
            if (state_q == 4'(2*n + 2)) begin
              if (fsm_q == MOVE)      ps_d[4*n +: 4] = adv(player_state[4*n +: 4]);
              else if (fsm_q == IDLE) ps_d[4*n +: 4] = 4'd0;
            end
          end
        end
      end
    end

    moving_d = (fsm_d == MOVE);
  end

endmodule

// File: tb/tb_player_controller.sv
// Directed bench for player_controller: reset, movement/clamping, animation,
// title preview, respawn collision and reset override.
module tb_player_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  state;
  logic        frame_tick;
  logic        key_up, key_down, key_left, key_right;
  logic [8:0]  player_x, player_y;
  logic [11:0] player_state;
  logic        moving;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_v;

  always #5 clk = ~clk;

  player_controller dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .frame_tick   (frame_tick),
    .key_up       (key_up),
    .key_down     (key_down),
    .key_left     (key_left),
    .key_right    (key_right),
    .player_x     (player_x),
    .player_y     (player_y),
    .player_state (player_state),
    .moving       (moving)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset(input logic [3:0] st);
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0;
    frame_tick = 1'b0;
    state = st;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();
  endtask

  initial begin
    rst = 1'b1; state = 4'd0; frame_tick = 1'b0;
    key_up = 1'b1; key_down = 1'b1; key_left = 1'b1; key_right = 1'b1;

    // Reset with all keys held
    step();
    step();
    check("reset_x", 12'(player_x), 12'd20);
    check("reset_y", 12'(player_y), 12'd110);
    check("reset_ps", player_state, 12'h000);
    check("reset_moving", 12'(moving), 12'd0);

    // STAGE1, hold left: one pixel every two ticks, clamp at 0
    do_reset(4'd2);
    key_left = 1'b1;
    step();
    check("move_enter", 12'(moving), 12'd1);
    for (int t = 1; t <= 60; t++) begin
      tick();
      exp_v = (t / 2 >= 20) ? 0 : 20 - t / 2;
      check("left_x", 12'(player_x), 12'(exp_v));
      check("left_y", 12'(player_y), 12'd110);
    end
    key_left = 1'b0;
    step();
    check("move_exit", 12'(moving), 12'd0);

    // STAGE1, hold right: nibble 0 advances on every 8th tick
    do_reset(4'd2);
    key_right = 1'b1;
    step();
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (t % 8 == 0) begin
        exp_v = (t / 8) % 4;
        check("anim_s1", player_state, 12'(exp_v));
      end
    end
    check("right_x", 12'(player_x), 12'd40);
    key_right = 1'b0;
    step();
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 7) check("idle_hold", player_state, 12'h001);
      if (t == 8) check("idle_zero", player_state, 12'h000);
    end

    // TITLE preview: all nibbles advance, position fixed
    do_reset(4'd0);
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (t == 7)  check("title_7", player_state, 12'h000);
      if (t == 8)  check("title_8", player_state, 12'h111);
      if (t == 16) check("title_16", player_state, 12'h222);
    end
    check("title_x", 12'(player_x), 12'd20);
    check("title_y", 12'(player_y), 12'd110);

    // Respawn on state change coinciding with a frame tick
    do_reset(4'd2);
    key_right = 1'b1;
    step();
    repeat (160) tick();
    check("pre_spawn_x", 12'(player_x), 12'd100);
    check("pre_spawn_ps", player_state, 12'h000);
    state = 4'd4;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    check("spawn_x", 12'(player_x), 12'd20);
    check("spawn_y", 12'(player_y), 12'd110);
    check("spawn_moving", 12'(moving), 12'd0);
    step();
    check("spawn_state_moving", 12'(moving), 12'd0);
    step();
    check("respawn_move", 12'(moving), 12'd1);
    check("respawn_x0", 12'(player_x), 12'd20);
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) check("respawn_x1", 12'(player_x), 12'd20);
      if (t == 2) check("respawn_x2", 12'(player_x), 12'd21);
      if (t == 7) check("respawn_ps7", player_state, 12'h000);
      if (t == 8) check("respawn_ps8", player_state, 12'h010);
    end

    // STAGE3, up+right: up wins, y clamps at 0, nibble 2 animates
    do_reset(4'd6);
    key_up = 1'b1;
    key_right = 1'b1;
    step();
    repeat (210) tick();
    check("s3_y5", 12'(player_y), 12'd5);
    check("s3_x", 12'(player_x), 12'd20);
    check("s3_ps210", player_state, 12'h200);
    for (int t = 1; t <= 22; t++) begin
      tick();
      exp_v = (t / 2 >= 5) ? 0 : 5 - t / 2;
      check("s3_up_y", 12'(player_y), 12'(exp_v));
    end
    check("s3_x_hold", 12'(player_x), 12'd20);
    check("s3_ps232", player_state, 12'h100);

    // Reset mid-move with a coincident tick
    rst = 1'b1;
    frame_tick = 1'b1;
    step();
    check("midrst_x", 12'(player_x), 12'd20);
    check("midrst_y", 12'(player_y), 12'd110);
    check("midrst_ps", player_state, 12'h000);
    check("midrst_moving", 12'(moving), 12'd0);
    rst = 1'b0;
    frame_tick = 1'b0;
    key_up = 1'b0;
    key_right = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
